// File: rtl/fifo_packer_nto1.sv
// N:1 width packer from a non-FWFT source FIFO into a wide destination FIFO, with threshold-triggered fixed bursts.
// Define PACKER_FLUSH_EN to drain the sub-threshold residue (PAD-completed) when a run ends.
module fifo_packer_nto1 #(
    parameter int              IN_W   = 32,
    parameter int              RATIO  = 2,
    parameter int              CNT_W  = 17,
    parameter int              THRESH = 'h100,
    parameter logic [IN_W-1:0] PAD    = 'hF0F0F0F0
) (
    input  logic                  digiclk_i,
    input  logic                  reset_i,
    input  logic                  mem_en_i,
    input  logic                  last_write_i,
    input  logic [CNT_W-1:0]      src_rdcnt_i,
    input  logic [IN_W-1:0]       src_data_i,
    output logic                  src_re_o,
    input  logic                  dst_empty_i,
    input  logic                  dst_afull_i,
    output logic                  dst_we_o,
    output logic [IN_W*RATIO-1:0] dst_data_o,
    output logic                  busy_o
);

    localparam int                LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int                TH_W      = $clog2(THRESH + 1);
    localparam int                BL_W      = ((TH_W > CNT_W) ? TH_W : CNT_W) + 1;
    localparam logic [BL_W-1:0]   THRESH_BL = BL_W'(THRESH);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
`ifdef PACKER_FLUSH_EN
        , FLUSH
`endif
    } state_t;

    state_t                  state, state_next;
    logic                    daq_ready, hold, go, pace_ok;
    logic                    rd_vld, step, load_burst;
    logic [BL_W-1:0]         burst_left, rdcnt_ext;
    logic [LANE_W-1:0]       lane_idx;
    logic [IN_W-1:0]         lanes [RATIO];
    logic                    word_vld;
    logic [IN_W-1:0]         word_in;
    logic [IN_W*RATIO-1:0]   packed_word;

`ifdef PACKER_FLUSH_EN
    localparam logic [BL_W-1:0] ROUND_MASK = BL_W'(RATIO - 1);
    logic            load_flush, flush_start, pad_vld;
    logic [BL_W-1:0] real_left;
    assign flush_start = daq_ready & last_write_i & ~mem_en_i &
                         (rdcnt_ext != '0) & (rdcnt_ext < THRESH_BL);
`endif

    assign rdcnt_ext = BL_W'(src_rdcnt_i);
    assign go        = daq_ready & ~hold & (rdcnt_ext >= THRESH_BL);
    assign pace_ok   = ~dst_afull_i & ~hold;
    assign busy_o    = (state != IDLE);

    always_ff @(posedge digiclk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            daq_ready <= 1'b0;
            hold      <= 1'b0;
        end else begin
            state <= state_next;
            if (mem_en_i)          daq_ready <= 1'b1;
            else if (last_write_i) daq_ready <= 1'b0;
            if (dst_afull_i)       hold <= 1'b1;
            else if (dst_empty_i)  hold <= 1'b0;
        end
    end

    // step = one lane slot consumed this clk; the burst ends on the clk its last read issues
    always_comb begin
        state_next = state;
        src_re_o   = 1'b0;
        step       = 1'b0;
        load_burst = 1'b0;
`ifdef PACKER_FLUSH_EN
        load_flush = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (go) begin
                    state_next = BURST;
                    load_burst = 1'b1;
                end
`ifdef PACKER_FLUSH_EN
                else if (flush_start) begin
                    state_next = FLUSH;
                    load_flush = 1'b1;
                end
`endif
            end
            BURST: begin
                step     = pace_ok & (burst_left != '0);
                src_re_o = step;
                if (burst_left == '0 || (step && burst_left == BL_W'(1)))
                    state_next = DRAIN;
            end
`ifdef PACKER_FLUSH_EN
            FLUSH: begin
                step     = pace_ok & (burst_left != '0);
                src_re_o = step & (real_left != '0);
                if (burst_left == '0 || (step && burst_left == BL_W'(1)))
                    state_next = DRAIN;
            end
`endif
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge digiclk_i) begin
        if (reset_i)         burst_left <= '0;
        else if (load_burst) burst_left <= THRESH_BL;
`ifdef PACKER_FLUSH_EN
        else if (load_flush) burst_left <= (rdcnt_ext + ROUND_MASK) & ~ROUND_MASK;
`endif
        else if (step)       burst_left <= burst_left - BL_W'(1);
    end

`ifdef PACKER_FLUSH_EN
    // Slots past the real residue become PAD lanes to complete the final word
    always_ff @(posedge digiclk_i) begin
        if (reset_i) begin
            real_left <= '0;
            pad_vld   <= 1'b0;
        end else begin
            pad_vld <= step & ~src_re_o;
            if (load_flush)                       real_left <= rdcnt_ext;
            else if (src_re_o && real_left != '0) real_left <= real_left - BL_W'(1);
        end
    end
`endif

    always_comb begin
        word_vld = rd_vld;
        word_in  = src_data_i;
`ifdef PACKER_FLUSH_EN
        if (pad_vld) begin
            word_vld = 1'b1;
            word_in  = PAD;
        end
`endif
    end

    always_comb begin
        packed_word = '0;
        for (int i = 0; i < RATIO; i++)
            packed_word[i*IN_W +: IN_W] = (i == RATIO - 1) ? word_in : lanes[i];
    end

    always_ff @(posedge digiclk_i) begin
        if (word_vld) lanes[lane_idx] <= word_in;
    end

    always_ff @(posedge digiclk_i) begin
        if (reset_i) begin
            rd_vld     <= 1'b0;
            lane_idx   <= '0;
            dst_we_o   <= 1'b0;
            dst_data_o <= {RATIO{PAD}};
        end else begin
            rd_vld   <= src_re_o;
            dst_we_o <= 1'b0;
            if (word_vld) begin
                if (lane_idx == LAST_LANE) begin
                    lane_idx   <= '0;
                    dst_we_o   <= 1'b1;
                    dst_data_o <= packed_word;
                end else begin
                    lane_idx <= lane_idx + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_packer_nto1.sv
// Self-checking bench for fifo_packer_nto1 (RATIO=4, THRESH=8): source FIFO modelled as a queue,
// expected output words formed by grouping popped source words in read order.
module tb_fifo_packer_nto1;

    localparam int IN_W   = 32;
    localparam int RATIO  = 4;
    localparam int CNT_W  = 17;
    localparam int THRESH = 8;
    localparam int OUT_W  = IN_W * RATIO;
    localparam logic [IN_W-1:0] PAD = 32'hF0F0F0F0;

    logic             digiclk_i, reset_i, mem_en_i, last_write_i;
    logic [CNT_W-1:0] src_rdcnt_i;
    logic [IN_W-1:0]  src_data_i;
    logic             src_re_o, dst_empty_i, dst_afull_i, dst_we_o, busy_o;
    logic [OUT_W-1:0] dst_data_o;

    fifo_packer_nto1 #(
        .IN_W(IN_W), .RATIO(RATIO), .CNT_W(CNT_W), .THRESH(THRESH), .PAD(PAD)
    ) dut (
        .digiclk_i   (digiclk_i),
        .reset_i     (reset_i),
        .mem_en_i    (mem_en_i),
        .last_write_i(last_write_i),
        .src_rdcnt_i (src_rdcnt_i),
        .src_data_i  (src_data_i),
        .src_re_o    (src_re_o),
        .dst_empty_i (dst_empty_i),
        .dst_afull_i (dst_afull_i),
        .dst_we_o    (dst_we_o),
        .dst_data_o  (dst_data_o),
        .busy_o      (busy_o)
    );

    initial digiclk_i = 1'b0;
    always #5 digiclk_i = ~digiclk_i;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0, last_re_cyc = 0, last_we_cyc = 0, busy_fall_cyc = 0;
    int rd_total = 0, rd_since_rst = 0;
    bit prev_busy = 1'b0;
    logic [IN_W-1:0]  src_q [$];
    logic [IN_W-1:0]  pend_q [$];
    logic [OUT_W-1:0] exp_q [$];
    logic [OUT_W-1:0] got_q [$];

    task automatic checkOutput(input string tag, input logic [OUT_W-1:0] observed,
                               input logic [OUT_W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock: present inputs, sample re, take the edge, then answer reads and score writes.
    task automatic applyStimulus();
        logic re_now, afull_now, rst_now;
        logic [OUT_W-1:0] w;
        src_rdcnt_i = CNT_W'(src_q.size());
        #1;
        re_now    = src_re_o;
        afull_now = dst_afull_i;
        rst_now   = reset_i;
        if (afull_now) checkOutput("re_under_afull", OUT_W'(re_now), '0);
        if (re_now === 1'b1) begin
            last_re_cyc = cyc;
            rd_total++;
            rd_since_rst++;
        end
        @(posedge digiclk_i);
        cyc++;
        #1;
        if (rst_now) begin
            exp_q.delete();
            pend_q.delete();
            rd_since_rst = 0;
        end
        if (dst_we_o === 1'b1) begin
            got_q.push_back(dst_data_o);
            last_we_cyc = cyc;
            checkOutput("we_expected", OUT_W'(exp_q.size() != 0), OUT_W'(1));
            if (exp_q.size() != 0) checkOutput("dst_data", dst_data_o, exp_q.pop_front());
        end
        if (prev_busy && busy_o === 1'b0) busy_fall_cyc = cyc;
        prev_busy = (busy_o === 1'b1);
        if (re_now === 1'b1) begin
            checkOutput("src_underflow", OUT_W'(src_q.size() == 0), '0);
            if (src_q.size() == 0) src_data_i = $urandom();
            else begin
                src_data_i = src_q.pop_front();
                if (!rst_now) begin
                    pend_q.push_back(src_data_i);
                    if (pend_q.size() == RATIO) begin
                        w = '0;
                        foreach (pend_q[i]) w[i*IN_W +: IN_W] = pend_q[i];
                        exp_q.push_back(w);
                        pend_q.delete();
                    end
                end
            end
        end else begin
            src_data_i = $urandom();
        end
    endtask

    task automatic waitReads(input int target, input int budget);
        int n = 0;
        while (rd_total < target && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput("wait_reads", OUT_W'(rd_total >= target), OUT_W'(1));
    endtask

    task automatic pushRandom(input int n);
        for (int i = 0; i < n; i++) src_q.push_back($urandom());
    endtask

    initial begin
        int base, base2, p0, n;
        reset_i = 1'b1; mem_en_i = 1'b0; last_write_i = 1'b0;
        dst_afull_i = 1'b0; dst_empty_i = 1'b0; src_data_i = '0;
        repeat (3) applyStimulus();
        checkOutput("rst_src_re",   OUT_W'(src_re_o), '0);
        checkOutput("rst_dst_we",   OUT_W'(dst_we_o), '0);
        checkOutput("rst_dst_data", dst_data_o, {RATIO{PAD}});
        checkOutput("rst_busy",     OUT_W'(busy_o), '0);
        reset_i = 1'b0;

        $display("[TB] below-threshold hold-off, then one burst of known words");
        for (int i = 1; i <= 3; i++) src_q.push_back(IN_W'(i));
        mem_en_i = 1'b1; applyStimulus(); mem_en_i = 1'b0;
        base = rd_total;
        repeat (10) applyStimulus();
        checkOutput("below_thresh_reads", OUT_W'(rd_total - base), '0);
        for (int i = 4; i <= 8; i++) src_q.push_back(IN_W'(i));
        got_q.delete();
        waitReads(base + 8, 40);
        repeat (6) applyStimulus();
        checkOutput("burst_len",   OUT_W'(rd_total - base), OUT_W'(8));
        checkOutput("burst_words", OUT_W'(got_q.size()), OUT_W'(2));
        if (got_q.size() == 2) begin
            checkOutput("word0_lanes", got_q[0], 128'h00000004_00000003_00000002_00000001);
            checkOutput("word1_lanes", got_q[1], 128'h00000008_00000007_00000006_00000005);
        end
        checkOutput("busy_fall_delay", OUT_W'(busy_fall_cyc - last_re_cyc), OUT_W'(2));
        checkOutput("we_latency",      OUT_W'(last_we_cyc - last_re_cyc), OUT_W'(2));

        $display("[TB] almost-full pause with hysteresis");
        pushRandom(8);
        base = rd_total;
        waitReads(base + 3, 30);
        dst_afull_i = 1'b1; p0 = rd_total;
        repeat (5) applyStimulus();
        dst_afull_i = 1'b0;
        repeat (4) applyStimulus();
        checkOutput("pause_reads", OUT_W'(rd_total - p0), '0);
        dst_empty_i = 1'b1; applyStimulus(); dst_empty_i = 1'b0;
        waitReads(base + 8, 40);
        repeat (6) applyStimulus();
        checkOutput("pause_burst_len", OUT_W'(rd_total - base), OUT_W'(8));

        $display("[TB] last_write mid-burst");
        pushRandom(11);
        base = rd_total;
        waitReads(base + 2, 30);
        last_write_i = 1'b1; applyStimulus(); last_write_i = 1'b0;
        repeat (20) applyStimulus();
        checkOutput("lw_burst_len", OUT_W'(rd_total - base), OUT_W'(8));
        checkOutput("lw_residue",   OUT_W'(src_q.size()), OUT_W'(3));
        pushRandom(8);
        base2 = rd_total;
        repeat (20) applyStimulus();
        checkOutput("lw_blocked", OUT_W'(rd_total - base2), '0);
        mem_en_i = 1'b1; applyStimulus(); mem_en_i = 1'b0;
        waitReads(base2 + 8, 30);
        repeat (4) applyStimulus();
        checkOutput("restart_len", OUT_W'(rd_total - base2), OUT_W'(8));

        $display("[TB] reset mid-burst with a partial word");
        pushRandom(8);
        base = rd_total;
        waitReads(base + 2, 30);
        reset_i = 1'b1; applyStimulus(); reset_i = 1'b0;
        checkOutput("mid_rst_src_re",   OUT_W'(src_re_o), '0);
        checkOutput("mid_rst_dst_we",   OUT_W'(dst_we_o), '0);
        checkOutput("mid_rst_dst_data", dst_data_o, {RATIO{PAD}});
        checkOutput("mid_rst_busy",     OUT_W'(busy_o), '0);
        pushRandom(8);
        mem_en_i = 1'b1; applyStimulus(); mem_en_i = 1'b0;
        got_q.delete();
        base = rd_total;
        waitReads(base + 8, 30);
        repeat (4) applyStimulus();
        checkOutput("post_rst_words", OUT_W'(got_q.size()), OUT_W'(2));

        $display("[TB] randomized traffic");
        mem_en_i = 1'b1; applyStimulus(); mem_en_i = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (src_q.size() < 40 && $urandom_range(0, 1) == 0) pushRandom($urandom_range(1, 3));
            dst_afull_i  = ($urandom_range(0, 9) == 0);
            dst_empty_i  = ($urandom_range(0, 5) == 0);
            mem_en_i     = ($urandom_range(0, 10) == 0);
            last_write_i = ($urandom_range(0, 30) == 0);
            applyStimulus();
        end
        dst_afull_i = 1'b0; mem_en_i = 1'b0;
        last_write_i = 1'b1; applyStimulus(); last_write_i = 1'b0;
        dst_empty_i = 1'b1; applyStimulus(); dst_empty_i = 1'b0;
        n = 0;
        while (busy_o === 1'b1 && n < 60) begin
            applyStimulus();
            n++;
        end
        repeat (4) applyStimulus();
        checkOutput("quiesce_busy",     OUT_W'(busy_o), '0);
        checkOutput("leftover_exp",     OUT_W'(exp_q.size()), '0);
        checkOutput("leftover_pend",    OUT_W'(pend_q.size()), '0);
        checkOutput("burst_accounting", OUT_W'(rd_since_rst % THRESH), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
